// File: rtl/equalizer_sdiv_pkg.sv
// Shared types, widths and helpers for the equalizer's sequential signed divider.
package equalizer_sdiv_pkg;

  localparam int DW_DEF  = 22;
  localparam int DVW_DEF = 16;
  localparam int QW_DEF  = 16;

  localparam int CNT_W = $clog2(DW_DEF);
  localparam int Q_MAX = (2 ** (QW_DEF - 1)) - 1;
  localparam int Q_MIN = -(2 ** (QW_DEF - 1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  // One extra bit so that the magnitude of the most negative value is exact.
  function automatic logic [DW_DEF:0] abs_ext(input logic signed [DW_DEF-1:0] v);
    logic signed [DW_DEF:0] x;
    x = {v[DW_DEF-1], v};
    return x[DW_DEF] ? -x : x;
  endfunction

endpackage

// File: rtl/equalizer_sdiv_step.sv
// One radix-2 restoring division step: shift in a dividend bit, compare, subtract.
module equalizer_sdiv_step #(
  parameter int PW = 17,
  parameter int MW = 17
) (
  input  logic [PW-1:0] rem_in,
  input  logic          bit_in,
  input  logic [MW-1:0] div_mag,
  output logic [PW-1:0] rem_out,
  output logic          q_bit
);

  logic [PW:0] shifted;

  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= (PW+1)'(div_mag));
    rem_out = q_bit ? PW'(shifted - (PW+1)'(div_mag)) : PW'(shifted);
  end

endmodule

// File: rtl/equalizer_sdiv_22s_16s_16_seq.sv
// Sequential signed divider (22s / 16s -> 16s quotient), one quotient bit per cycle.
// Build option: define EQ_SDIV_SATURATE_EN to clamp overflowing quotients instead of wrapping.
module equalizer_sdiv_22s_16s_16_seq
  import equalizer_sdiv_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DW_DEF,
  parameter int DIVISOR_WIDTH  = DVW_DEF,
  parameter int QUOTIENT_WIDTH = QW_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ce,
  input  logic                              start,
  input  logic signed [DIVIDEND_WIDTH-1:0]  din0,
  input  logic signed [DIVISOR_WIDTH-1:0]   din1,
  output logic                              ready,
  output logic                              dout_vld,
  output logic signed [QUOTIENT_WIDTH-1:0]  dout,
  output logic signed [DIVISOR_WIDTH-1:0]   rem,
  output logic                              div_zero,
  output logic                              ovf
);

  localparam int PW = DIVISOR_WIDTH + 1;
  localparam logic signed [DIVIDEND_WIDTH:0] QMAX_X = (DIVIDEND_WIDTH+1)'(Q_MAX);
  localparam logic signed [DIVIDEND_WIDTH:0] QMIN_X = (DIVIDEND_WIDTH+1)'(Q_MIN);
  localparam logic signed [QUOTIENT_WIDTH-1:0] QMAX_W = QUOTIENT_WIDTH'(Q_MAX);
  localparam logic signed [QUOTIENT_WIDTH-1:0] QMIN_W = QUOTIENT_WIDTH'(Q_MIN);

  state_t state, next_state;

  logic [CNT_W-1:0]          cnt;
  logic [DIVIDEND_WIDTH-1:0] work;
  logic [PW-1:0]             dvs_mag;
  logic [PW-1:0]             prem;
  logic                      sign0, sign1, dz;

  logic [PW-1:0] step_rem;
  logic          step_q;

  logic                               q_neg, q_ovf;
  logic signed [DIVIDEND_WIDTH:0]     q_ext, q_sgn;
  logic signed [QUOTIENT_WIDTH-1:0]   dout_n;
  logic signed [DIVISOR_WIDTH-1:0]    rem_n;

  // The work register starts as the dividend magnitude and fills with quotient bits from the bottom.
  equalizer_sdiv_step #(.PW(PW), .MW(PW)) u_step (
    .rem_in (prem),
    .bit_in (work[DIVIDEND_WIDTH-1]),
    .div_mag(dvs_mag),
    .rem_out(step_rem),
    .q_bit  (step_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else if (ce) state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) next_state = S_CALC;
      end
      S_CALC: if (cnt == CNT_W'(DIVIDEND_WIDTH - 1)) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Sign correction and overflow detection on the finished magnitudes.
  always_comb begin
    q_neg  = sign0 ^ sign1;
    q_ext  = {1'b0, work};
    q_sgn  = q_neg ? -q_ext : q_ext;
    q_ovf  = (q_sgn > QMAX_X) || (q_sgn < QMIN_X);
    rem_n  = dz ? '0 : DIVISOR_WIDTH'(sign0 ? -prem : prem);
    dout_n = QUOTIENT_WIDTH'(q_sgn);
    if (dz) begin
      dout_n = sign0 ? QMIN_W : QMAX_W;
    end
`ifdef EQ_SDIV_SATURATE_EN
    else if (q_ovf) begin
      dout_n = q_neg ? QMIN_W : QMAX_W;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      work     <= '0;
      dvs_mag  <= '0;
      prem     <= '0;
      sign0    <= 1'b0;
      sign1    <= 1'b0;
      dz       <= 1'b0;
      dout_vld <= 1'b0;
      dout     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else if (ce) begin
      dout_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            work    <= DIVIDEND_WIDTH'(abs_ext(din0));
            dvs_mag <= PW'(abs_ext(DIVIDEND_WIDTH'(din1)));
            sign0   <= din0[DIVIDEND_WIDTH-1];
            sign1   <= din1[DIVISOR_WIDTH-1];
            dz      <= (din1 == '0);
            prem    <= '0;
            cnt     <= '0;
          end
        end
        S_CALC: begin
          prem <= step_rem;
          work <= {work[DIVIDEND_WIDTH-2:0], step_q};
          cnt  <= cnt + CNT_W'(1);
        end
        S_DONE: begin
          dout_vld <= 1'b1;
          dout     <= dout_n;
          rem      <= rem_n;
          div_zero <= dz;
          ovf      <= dz | q_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule
